// File: rtl/fetch_stage.sv
// IF stage: single-outstanding instruction fetch, static next-PC prediction
// (JAL/branch taken), F predicted-PC register and the D-side pipeline register.
module fetch_stage #(
    parameter int unsigned      PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      INSTR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    input  logic                   redirect_i,
    input  logic                   stall_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic [PC_WIDTH-1:0]    f_predPC_o,
    output logic [PC_WIDTH-1:0]    F_predPC_o,
    output logic                   D_valid_o,
    output logic [PC_WIDTH-1:0]    D_pc_o,
    output logic [INSTR_WIDTH-1:0] D_instr_o,
    output logic [PC_WIDTH-1:0]    D_delayPC_o,
    output logic [1:0]             dbg_state_o
);

    // Handshakes: a request is issued in any cycle where imem_req_o && imem_gnt_i;
    // responses return in order on imem_rvalid_i; the D register is held whenever
    // stall_i && D_valid_o, and holds its last delivery until replaced or flushed.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q;
    logic [INSTR_WIDTH-1:0] hold_q;
    logic [INSTR_WIDTH-1:0] src_instr;
    logic [PC_WIDTH-1:0]    j_imm;
    logic [PC_WIDTH-1:0]    b_imm;
    logic                   can_load;
    logic                   issue;
    logic                   deliver;
    logic                   buffer;

    assign dbg_state_o = state_q;
    assign imem_addr_o = pc_i;
    assign can_load    = !stall_i || !D_valid_o;

    // Prediction always looks at the instruction that would be delivered now.
    assign src_instr = (state_q == HOLD) ? hold_q : imem_rdata_i;
    assign j_imm = {{(PC_WIDTH-21){src_instr[31]}}, src_instr[31], src_instr[19:12],
                    src_instr[20], src_instr[30:21], 1'b0};
    assign b_imm = {{(PC_WIDTH-13){src_instr[31]}}, src_instr[31], src_instr[7],
                    src_instr[30:25], src_instr[11:8], 1'b0};

    always_comb begin
        f_predPC_o = fetch_pc_q + PC_WIDTH'(4);
        case (src_instr[6:0])
            7'b1101111: f_predPC_o = fetch_pc_q + j_imm;
            7'b1100011: f_predPC_o = fetch_pc_q + b_imm;
            default:    f_predPC_o = fetch_pc_q + PC_WIDTH'(4);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        deliver    = 1'b0;
        buffer     = 1'b0;
        imem_req_o = (state_q == IDLE) && !rst_i && (redirect_i || can_load);
        issue      = imem_req_o && imem_gnt_i;
        case (state_q)
            IDLE: begin
                if (issue) state_d = WAIT;
            end
            WAIT: begin
                if (redirect_i) begin
                    state_d = imem_rvalid_i ? IDLE : DROP;
                end else if (imem_rvalid_i) begin
                    if (can_load) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        buffer  = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    state_d = IDLE;
                end else if (can_load) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                // The response still owed to the flushed fetch retires here.
                if (imem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fetch_pc_q  <= '0;
            hold_q      <= '0;
            F_predPC_o  <= RESET_PC;
            D_valid_o   <= 1'b0;
            D_pc_o      <= '0;
            D_instr_o   <= '0;
            D_delayPC_o <= '0;
        end else begin
            state_q <= state_d;
            if (issue) fetch_pc_q <= pc_i;
            if (buffer) hold_q <= imem_rdata_i;
            if (redirect_i) begin
                D_valid_o  <= 1'b0;
                F_predPC_o <= pc_i;
            end else if (deliver) begin
                D_valid_o   <= 1'b1;
                D_pc_o      <= fetch_pc_q;
                D_instr_o   <= src_instr;
                D_delayPC_o <= fetch_pc_q + PC_WIDTH'(4);
                F_predPC_o  <= f_predPC_o;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free run, prediction, stall/HOLD, redirect
// in WAIT (with and without same-cycle response), redirect in IDLE, reset mid-fetch.
module tb_fetch_stage;

    localparam logic [31:0] ADDI1 = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_0113;
    localparam logic [31:0] JAL20 = 32'h0200_00EF;
    localparam logic [31:0] BEQM8 = 32'hFE00_0CE3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        redirect_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] f_predPC_o;
    logic [31:0] F_predPC_o;
    logic        D_valid_o;
    logic [31:0] D_pc_o;
    logic [31:0] D_instr_o;
    logic [31:0] D_delayPC_o;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0), .INSTR_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .redirect_i    (redirect_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .f_predPC_o    (f_predPC_o),
        .F_predPC_o    (F_predPC_o),
        .D_valid_o     (D_valid_o),
        .D_pc_o        (D_pc_o),
        .D_instr_o     (D_instr_o),
        .D_delayPC_o   (D_delayPC_o),
        .dbg_state_o   (dbg_state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One unstalled fetch with 1-cycle memory latency, checked end to end.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pred);
        pc_i = pc;
        imem_gnt_i = 1'b1;
        #1;
        chk("req", {31'b0, imem_req_o}, 32'd1);
        chk("addr", imem_addr_o, pc);
        tick();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = instr;
        #1;
        chk("f_pred", f_predPC_o, pred);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        chk("d_valid", {31'b0, D_valid_o}, 32'd1);
        chk("d_pc", D_pc_o, pc);
        chk("d_instr", D_instr_o, instr);
        chk("d_delay", D_delayPC_o, pc + 32'd4);
        chk("F_pred", F_predPC_o, pred);
    endtask

    initial begin
        rst_i = 1'b1;
        pc_i = 32'h0;
        redirect_i = 1'b0;
        stall_i = 1'b0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;

        // Reset state
        tick();
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        tick();
        chk("rst_F", F_predPC_o, 32'h0);
        chk("rst_dvalid", {31'b0, D_valid_o}, 32'd0);
        chk("rst_dpc", D_pc_o, 32'h0);
        chk("rst_ddelay", D_delayPC_o, 32'h0);
        chk("rst_state", {30'b0, dbg_state_o}, 32'd0);
        rst_i = 1'b0;

        // Free run
        fetch(32'h0, ADDI1, 32'h4);
        fetch(32'h4, ADDI1, 32'h8);
        fetch(32'h8, ADDI1, 32'hC);

        // Prediction: JAL +0x20, then BEQ -8
        fetch(32'h10, JAL20, 32'h30);
        fetch(32'h30, ADDI1, 32'h34);
        fetch(32'h40, BEQM8, 32'h38);

        // Stalled in IDLE with a valid D: no request
        stall_i = 1'b1;
        pc_i = 32'h38;
        #1;
        chk("stall_idle_req", {31'b0, imem_req_o}, 32'd0);

        // Response arrives under stall -> HOLD for 3 cycles
        stall_i = 1'b0;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        stall_i = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = ADDI2;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_state", {30'b0, dbg_state_o}, 32'd2);
            chk("hold_dpc", D_pc_o, 32'h40);
            chk("hold_dinstr", D_instr_o, BEQM8);
            chk("hold_F", F_predPC_o, 32'h38);
            chk("hold_req", {31'b0, imem_req_o}, 32'd0);
            tick();
        end
        chk("hold3_state", {30'b0, dbg_state_o}, 32'd2);
        stall_i = 1'b0;
        pc_i = 32'h3C;
        tick();
        chk("unhold_dvalid", {31'b0, D_valid_o}, 32'd1);
        chk("unhold_dpc", D_pc_o, 32'h38);
        chk("unhold_dinstr", D_instr_o, ADDI2);
        chk("unhold_F", F_predPC_o, 32'h3C);
        chk("unhold_state", {30'b0, dbg_state_o}, 32'd0);
        tick();
        chk("no_dup_state", {30'b0, dbg_state_o}, 32'd0);
        chk("no_dup_dpc", D_pc_o, 32'h38);

        // Redirect while waiting -> DROP, stale response discarded
        pc_i = 32'h8;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        redirect_i = 1'b1;
        pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        chk("drop_dvalid", {31'b0, D_valid_o}, 32'd0);
        chk("drop_F", F_predPC_o, 32'h100);
        chk("drop_state", {30'b0, dbg_state_o}, 32'd3);
        chk("drop_req", {31'b0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = ADDI2;
        tick();
        imem_rvalid_i = 1'b0;
        chk("drop_done_state", {30'b0, dbg_state_o}, 32'd0);
        chk("drop_done_dvalid", {31'b0, D_valid_o}, 32'd0);
        fetch(32'h100, ADDI1, 32'h104);

        // Redirect with same-cycle response
        pc_i = 32'h104;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = ADDI2;
        redirect_i = 1'b1;
        pc_i = 32'h200;
        tick();
        imem_rvalid_i = 1'b0;
        redirect_i = 1'b0;
        chk("redir_rv_dvalid", {31'b0, D_valid_o}, 32'd0);
        chk("redir_rv_F", F_predPC_o, 32'h200);
        chk("redir_rv_state", {30'b0, dbg_state_o}, 32'd0);
        chk("redir_rv_dpc", D_pc_o, 32'h100);

        // Redirect in IDLE with grant fetches the target
        pc_i = 32'h300;
        redirect_i = 1'b1;
        imem_gnt_i = 1'b1;
        tick();
        redirect_i = 1'b0;
        imem_gnt_i = 1'b0;
        chk("redir_idle_state", {30'b0, dbg_state_o}, 32'd1);
        chk("redir_idle_F", F_predPC_o, 32'h300);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = ADDI1;
        tick();
        imem_rvalid_i = 1'b0;
        chk("redir_idle_dpc", D_pc_o, 32'h300);
        chk("redir_idle_dvalid", {31'b0, D_valid_o}, 32'd1);

        // Reset while waiting; late response ignored
        pc_i = 32'h304;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_wait_F", F_predPC_o, 32'h0);
        chk("rst_wait_dvalid", {31'b0, D_valid_o}, 32'd0);
        chk("rst_wait_state", {30'b0, dbg_state_o}, 32'd0);
        pc_i = 32'h0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = ADDI2;
        tick();
        imem_rvalid_i = 1'b0;
        chk("late_rv_state", {30'b0, dbg_state_o}, 32'd0);
        chk("late_rv_dvalid", {31'b0, D_valid_o}, 32'd0);
        fetch(32'h0, ADDI1, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
